// File: rtl/pulse_freq_meter_pkg.sv
// rtl/pulse_freq_meter_pkg.sv - shared state type and defaults for the pulse frequency meter
package pulse_freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2
  } meter_state_t;

  localparam int unsigned DEF_GATE_CYCLES = 1_000_000;
  localparam int unsigned DEF_CNT_W       = 24;
  localparam int unsigned ARM_CYCLES      = 2;
  localparam int unsigned ARM_W           = $clog2(ARM_CYCLES);

endpackage

// File: rtl/pulse_freq_meter_if.sv
// rtl/pulse_freq_meter_if.sv - run request and measurement result bundle
interface pulse_freq_meter_if #(
  parameter int unsigned CNT_W = pulse_freq_meter_pkg::DEF_CNT_W
) ();

  logic             Enable;
  logic [CNT_W-1:0] Freq_Count;
  logic             Valid;
  logic             Overflow;
  logic             No_Signal;

  modport master (
    input  Enable,
    output Freq_Count,
    output Valid,
    output Overflow,
    output No_Signal
  );

  modport slave (
    output Enable,
    input  Freq_Count,
    input  Valid,
    input  Overflow,
    input  No_Signal
  );

endinterface

// File: rtl/pulse_freq_meter_sync_edge.sv
// rtl/pulse_freq_meter_sync_edge.sv - pulse_sync_edge: 2-flop synchronizer, history flop, rising-edge flag
module pulse_sync_edge (
  input  logic sysclk,
  input  logic reset,
  input  logic Pulse,
  output logic edge_flag
);

  logic sync1;
  logic sync2;
  logic hist;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= Pulse;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign edge_flag = sync2 & ~hist;

endmodule

// File: rtl/pulse_freq_meter.sv
// rtl/pulse_freq_meter.sv - counts Pulse rising edges over a fixed sysclk gate window
module pulse_freq_meter
  import pulse_freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               Pulse,
  pulse_freq_meter_if.master meter
);

  localparam int GATE_W = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  meter_state_t     state;
  meter_state_t     state_nxt;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [ARM_W-1:0] arm_cnt;
  logic             ovf;
  logic             edge_flag;
  logic             counting;
  logic             win_end;
  logic             at_max;
  logic [CNT_W-1:0] cnt_sum;
  logic             ovf_sum;

  pulse_sync_edge u_sync (
    .sysclk    (sysclk),
    .reset     (reset),
    .Pulse     (Pulse),
    .edge_flag (edge_flag)
  );

  // Count including this cycle's edge, so the closing cycle's edge lands in its own window.
  assign at_max  = (edge_cnt == CNT_MAX);
  assign cnt_sum = (edge_flag && !at_max) ? edge_cnt + CNT_W'(1) : edge_cnt;
  assign ovf_sum = ovf | (edge_flag & at_max);

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    counting  = 1'b0;
    win_end   = 1'b0;
    case (state)
      IDLE: if (meter.Enable) state_nxt = ARM;
      ARM: begin
        if (!meter.Enable)                           state_nxt = IDLE;
        else if (arm_cnt == ARM_W'(ARM_CYCLES - 1))  state_nxt = GATE;
      end
      GATE: begin
        counting = 1'b1;
        if (gate_cnt == GATE_LAST) begin
          win_end   = 1'b1;
          state_nxt = meter.Enable ? GATE : IDLE;
        end else if (!meter.Enable) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      arm_cnt          <= '0;
      gate_cnt         <= '0;
      edge_cnt         <= '0;
      ovf              <= 1'b0;
      meter.Valid      <= 1'b0;
      meter.Freq_Count <= '0;
      meter.Overflow   <= 1'b0;
      meter.No_Signal  <= 1'b0;
    end else begin
      meter.Valid <= win_end;
      arm_cnt     <= (state == ARM) ? arm_cnt + ARM_W'(1) : '0;
      // Edge flags outside GATE are dropped, flushing stale synchronizer history.
      if (counting && !win_end) begin
        gate_cnt <= gate_cnt + GATE_W'(1);
        edge_cnt <= cnt_sum;
        ovf      <= ovf_sum;
      end else begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        ovf      <= 1'b0;
      end
      if (win_end) begin
        meter.Freq_Count <= cnt_sum;
        meter.Overflow   <= ovf_sum;
        meter.No_Signal  <= (cnt_sum == '0);
      end
    end
  end

endmodule

// File: tb/tb_pulse_freq_meter.sv
// tb/tb_pulse_freq_meter.sv - self-checking bench for pulse_freq_meter
module tb_pulse_freq_meter;

  localparam int GC   = 100;
  localparam int MAXC = 20000;

  logic sysclk  = 1'b0;
  logic rst_n   = 1'b0;
  logic pulse_a = 1'b0;
  logic pulse_b = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit plog_a [MAXC];
  bit plog_b [MAXC];

  int mode_a = 0, per_a = 10, hi_a = 5, step_a = 0;
  int mode_b = 0, per_b = 2,  hi_b = 1;

  logic [63:0] last_cnt_a = '0;
  logic        last_ovf_a = 1'b0;
  logic        last_ns_a  = 1'b0;

  pulse_freq_meter_if #(.CNT_W(24)) ifa ();
  pulse_freq_meter_if #(.CNT_W(4))  ifb ();

  pulse_freq_meter #(.GATE_CYCLES(GC), .CNT_W(24)) dut_a (
    .sysclk (sysclk),
    .reset  (rst_n),
    .Pulse  (pulse_a),
    .meter  (ifa)
  );

  pulse_freq_meter #(.GATE_CYCLES(GC), .CNT_W(4)) dut_b (
    .sysclk (sysclk),
    .reset  (rst_n),
    .Pulse  (pulse_b),
    .meter  (ifb)
  );

  always #5 sysclk = ~sysclk;

  // Pulse as seen by the design at each clock edge; reset holds the synchronizer at 0.
  always @(posedge sysclk) begin
    if (cyc < MAXC) begin
      plog_a[cyc] = rst_n ? pulse_a : 1'b0;
      plog_b[cyc] = rst_n ? pulse_b : 1'b0;
    end
    cyc = cyc + 1;
  end

  function automatic bit gen(input int mode, input int per, input int hi, input int stp, input int idx);
    case (mode)
      1:       return 1'b1;
      2:       return (idx % per) < hi;
      3:       return bit'($urandom & 1);
      4:       return idx >= stp;
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge sysclk) begin
    pulse_a = gen(mode_a, per_a, hi_a, step_a, cyc);
    pulse_b = gen(mode_b, per_b, hi_b, 0, cyc);
  end

  function automatic bit sample(input bit b, input int idx);
    if (idx < 0 || idx >= MAXC) return 1'b0;
    return b ? plog_b[idx] : plog_a[idx];
  endfunction

  // Rising transitions of Pulse, seen two clocks late, over the GC clocks ending at last_edge.
  function automatic int raw_count(input bit b, input int last_edge);
    int c = 0;
    for (int m = last_edge - GC + 1; m <= last_edge; m++)
      if (sample(b, m - 2) && !sample(b, m - 3)) c++;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_window(input bit b, input int last_edge, input string tag);
    int raw;
    int mx;
    int ec;
    if (cyc > last_edge) chk({tag, "_late"}, 64'(cyc), 64'(last_edge));
    while (cyc < last_edge) @(negedge sysclk);
    chk({tag, "_pre_valid"}, b ? ifb.Valid : ifa.Valid, 0);
    @(negedge sysclk);
    raw = raw_count(b, last_edge);
    mx  = b ? 15 : (1 << 24) - 1;
    ec  = (raw > mx) ? mx : raw;
    chk({tag, "_valid"}, b ? ifb.Valid : ifa.Valid, 1);
    chk({tag, "_count"}, b ? 64'(ifb.Freq_Count) : 64'(ifa.Freq_Count), 64'(ec));
    chk({tag, "_ovf"}, b ? ifb.Overflow : ifa.Overflow, 64'(raw > mx));
    chk({tag, "_nosig"}, b ? ifb.No_Signal : ifa.No_Signal, 64'(ec == 0));
    if (!b) begin
      last_cnt_a = 64'(ec);
      last_ovf_a = (raw > mx);
      last_ns_a  = (ec == 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int L;
    int r;
    bit seen;
    ifa.Enable = 1'b0;
    ifb.Enable = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(negedge sysclk);
    chk("rst_count", ifa.Freq_Count, 0);
    chk("rst_valid", ifa.Valid, 0);
    chk("rst_ovf", ifa.Overflow, 0);
    chk("rst_nosig", ifa.No_Signal, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge sysclk);

    // Narrow counter saturates, then recovers with a slow input.
    mode_b = 2; per_b = 2; hi_b = 1;
    repeat (5) @(negedge sysclk);
    ifb.Enable = 1'b1;
    s = cyc;
    L = s + 2 + GC;
    expect_window(1, L, "sat1");
    chk("sat1_const_count", ifb.Freq_Count, 15);
    chk("sat1_const_ovf", ifb.Overflow, 1);
    per_b = 10; hi_b = 5;
    L += GC;
    expect_window(1, L, "sat2");
    L += GC;
    expect_window(1, L, "sat3");
    chk("sat3_const_count", ifb.Freq_Count, 10);
    chk("sat3_const_ovf", ifb.Overflow, 0);
    ifb.Enable = 1'b0;
    mode_b = 0;

    // Period-10 input, back-to-back windows.
    mode_a = 2; per_a = 10; hi_a = 5;
    repeat (3) @(negedge sysclk);
    ifa.Enable = 1'b1;
    s = cyc;
    L = s + 2 + GC;
    for (int k = 0; k < 3; k++) begin
      expect_window(0, L, "p10");
      chk("p10_const_count", ifa.Freq_Count, 10);
      chk("p10_const_nosig", ifa.No_Signal, 0);
      L += GC;
    end

    // Held high.
    mode_a = 1;
    for (int k = 0; k < 3; k++) begin
      expect_window(0, L, "high");
      L += GC;
    end
    chk("high_const_count", ifa.Freq_Count, 0);
    chk("high_const_nosig", ifa.No_Signal, 1);

    // Random bits, then random periods.
    mode_a = 3;
    for (int k = 0; k < 2; k++) begin
      expect_window(0, L, "rand_bits");
      L += GC;
    end
    mode_a = 2;
    for (int k = 0; k < 3; k++) begin
      per_a = $urandom_range(2, 30);
      hi_a  = $urandom_range(1, per_a - 1);
      expect_window(0, L, "rand_per");
      L += GC;
    end

    // Abort 50 cycles into a window.
    while (cyc < L - GC + 50) @(negedge sysclk);
    ifa.Enable = 1'b0;
    seen = 1'b0;
    while (cyc < L + 5) begin
      @(negedge sysclk);
      if (ifa.Valid === 1'b1) seen = 1'b1;
    end
    chk("abort_no_valid", seen, 0);
    chk("abort_hold_count", ifa.Freq_Count, last_cnt_a);
    chk("abort_hold_ovf", ifa.Overflow, last_ovf_a);
    chk("abort_hold_nosig", ifa.No_Signal, last_ns_a);
    ifa.Enable = 1'b1;
    s = cyc;
    L = s + 2 + GC;
    expect_window(0, L, "rearm");
    L += GC;

    // Enable falls in the closing cycle: window still completes, then idle.
    while (cyc < L) @(negedge sysclk);
    ifa.Enable = 1'b0;
    expect_window(0, L, "drop_last");
    seen = 1'b0;
    while (cyc < L + GC + 5) begin
      @(negedge sysclk);
      if (ifa.Valid === 1'b1) seen = 1'b1;
    end
    chk("drop_last_idle", seen, 0);

    // Single edge reaching the counter in the final gate cycle.
    mode_a = 0;
    repeat (5) @(negedge sysclk);
    ifa.Enable = 1'b1;
    s = cyc;
    L = s + 2 + GC;
    step_a = L - 2;
    mode_a = 4;
    expect_window(0, L, "edge_last");
    chk("edge_last_const", ifa.Freq_Count, 1);
    L += GC;
    expect_window(0, L, "edge_next");
    chk("edge_next_const", ifa.Freq_Count, 0);
    chk("edge_next_nosig", ifa.No_Signal, 1);
    L += GC;

    // Reset pulsed mid-window.
    mode_a = 2; per_a = 10; hi_a = 5;
    expect_window(0, L, "pre_rst");
    L += GC;
    while (cyc < L - GC + 40) @(negedge sysclk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", ifa.Freq_Count, 0);
    chk("arst_valid", ifa.Valid, 0);
    chk("arst_ovf", ifa.Overflow, 0);
    chk("arst_nosig", ifa.No_Signal, 0);
    @(negedge sysclk);
    rst_n = 1'b1;
    r = cyc;
    L = r + 2 + GC;
    expect_window(0, L, "post_rst");
    chk("post_rst_const", ifa.Freq_Count, 10);
    ifa.Enable = 1'b0;
    repeat (3) @(negedge sysclk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
